dvv_bus_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one single-outstanding bus master port among NREQ requesters.

---
 rtl/dvv_arb_pkg.sv | 19 +
 rtl/dvv_rr_pick.sv | 33 +++
 rtl/dvv_bus_arb.sv | 115 +++++++++++
 tb/tb_dvv_bus_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvv_arb_pkg.sv
// Shared types for the round-robin bus arbiter: FSM states, id width helper
// and the response-timeout counter type.
package dvv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Wide enough for the largest supported timeout (65535 cycles).
    localparam int TO_W = 16;
    typedef logic [TO_W-1:0] to_cnt_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dvv_rr_pick.sv
// Combinational rotate-priority picker: first asserted request searching
// upward from ptr+1 with wrap-around.
module dvv_rr_pick
    import dvv_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   id,
    output logic            any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

endmodule

// File: rtl/dvv_bus_arb.sv
// Round-robin sequencer sharing one single-outstanding bus master among NREQ
// requesters, with a response timeout so a hung target cannot lock the bus.
module dvv_bus_arb
    import dvv_arb_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int AW     = 32,
    parameter  int DW     = 32,
    parameter  int TO_CYC = 255,
    localparam int IW     = id_w(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_vld,
    output logic [NREQ-1:0]  req_rdy,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]  req_we,
    input  logic [NREQ*DW-1:0] req_wd,
    output logic [NREQ-1:0]  resp_vld,
    output logic [DW-1:0]    resp_rd,
    output logic             resp_err,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic [AW-1:0]    m_addr,
    output logic             m_we,
    output logic [DW-1:0]    m_wd,
    input  logic             m_resp_vld,
    input  logic [DW-1:0]    m_rd,
    output logic             busy,
    output logic [IW-1:0]    cur_id
);

    arb_state_t              state;
    logic [IW-1:0]           ptr;
    to_cnt_t                 cnt;
    logic [NREQ-1:0][AW-1:0] addr_a;
    logic [NREQ-1:0][DW-1:0] wd_a;
    logic [NREQ-1:0]         pick_gnt;
    logic [IW-1:0]           pick_id;
    logic                    pick_any;
    logic                    grant_ok;

    assign addr_a = req_addr;
    assign wd_a   = req_wd;

    dvv_rr_pick #(.NREQ(NREQ)) u_pick (
        .req (req_vld),
        .ptr (ptr),
        .gnt (pick_gnt),
        .id  (pick_id),
        .any (pick_any)
    );

    // No grant while the previous owner's completion pulse is still out,
    // so every owner sees its response before the bus moves on.
    assign grant_ok = (state == ARB_IDLE) && !(|resp_vld) && !rst;
    assign req_rdy  = grant_ok ? pick_gnt : '0;
    assign busy     = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= IW'(NREQ - 1);
            cnt      <= '0;
            cur_id   <= '0;
            m_vld    <= 1'b0;
            m_addr   <= '0;
            m_we     <= 1'b0;
            m_wd     <= '0;
            resp_vld <= '0;
            resp_rd  <= '0;
            resp_err <= 1'b0;
        end else begin
            resp_vld <= '0;
            case (state)
                ARB_IDLE: begin
                    if (grant_ok && pick_any) begin
                        m_addr <= addr_a[pick_id];
                        m_we   <= req_we[pick_id];
                        m_wd   <= wd_a[pick_id];
                        m_vld  <= 1'b1;
                        cur_id <= pick_id;
                        ptr    <= pick_id;
                        state  <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (m_rdy) begin
                        m_vld <= 1'b0;
                        cnt   <= '0;
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // A response arriving on the timeout cycle still counts as normal.
                    if (m_resp_vld) begin
                        resp_vld[cur_id] <= 1'b1;
                        resp_rd          <= m_rd;
                        resp_err         <= 1'b0;
                        state            <= ARB_IDLE;
                    end else if (cnt == to_cnt_t'(TO_CYC - 1)) begin
                        resp_vld[cur_id] <= 1'b1;
                        resp_rd          <= '0;
                        resp_err         <= 1'b1;
                        state            <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + to_cnt_t'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dvv_bus_arb.sv
// Bench for dvv_bus_arb: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter.
module tb_dvv_bus_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld, req_rdy, req_we, resp_vld;
    logic [N*32-1:0] req_addr, req_wd;
    logic [31:0]     resp_rd, m_addr, m_wd, m_rd;
    logic            resp_err, m_vld, m_rdy, m_we, m_resp_vld, busy;
    logic [1:0]      cur_id;

    int n_cmp = 0;
    int n_bad = 0;

    dvv_bus_arb #(.NREQ(N), .AW(32), .DW(32), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_we(req_we), .req_wd(req_wd),
        .resp_vld(resp_vld), .resp_rd(resp_rd), .resp_err(resp_err),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_addr(m_addr), .m_we(m_we), .m_wd(m_wd),
        .m_resp_vld(m_resp_vld), .m_rd(m_rd),
        .busy(busy), .cur_id(cur_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2id(logic [N-1:0] v);
        int id = -1;
        for (int i = 0; i < N; i++)
            if (v[i]) id = (id == -1) ? i : -2;
        return id;
    endfunction

    // Round-robin rule: first asserted request searching from p+1 with wrap.
    function automatic logic [N-1:0] rr_win(int p, logic [N-1:0] v);
        logic [N-1:0] g = '0;
        for (int j = 1; j <= N; j++) begin
            if (g == 0 && v[(p + j) % N]) g[(p + j) % N] = 1'b1;
        end
        return g;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_vld = '1; #1;
        n_cmp++; if (req_rdy !== '0) begin n_bad++; $display("FAIL reset_rdy: got %b, expected 0", req_rdy); end
        tick(); tick();
        n_cmp++; if ({m_vld, busy, resp_vld, resp_err, cur_id, m_we} !== 10'd0) begin
            n_bad++; $display("FAIL reset_ctl: got %b, expected 0", {m_vld, busy, resp_vld, resp_err, cur_id, m_we}); end
        n_cmp++; if ({resp_rd, m_addr, m_wd} !== 96'd0) begin
            n_bad++; $display("FAIL reset_data: got %h, expected 0", {resp_rd, m_addr, m_wd}); end
        req_vld = '0; rst = 1'b0;
        tick(); tick();
        n_cmp++; if ({busy, m_vld, req_rdy} !== 6'd0) begin
            n_bad++; $display("FAIL idle_none: got %b, expected 0", {busy, m_vld, req_rdy}); end
    endtask

    task automatic test_single_read();
        req_addr[0 +: 32] = 32'h10; req_we[0] = 1'b0; req_vld = 4'b0001; m_rdy = 1'b1; #1;
        n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL sr_grant: got %b, expected 0001", req_rdy); end
        tick(); req_vld = '0;
        n_cmp++; if ({m_vld, m_we, m_addr, busy, cur_id} !== {1'b1, 1'b0, 32'h10, 1'b1, 2'd0}) begin
            n_bad++; $display("FAIL sr_issue: got vld=%b we=%b addr=%h busy=%b id=%0d", m_vld, m_we, m_addr, busy, cur_id); end
        tick();
        n_cmp++; if ({m_vld, busy} !== 2'b01) begin n_bad++; $display("FAIL sr_wait: got %b, expected 01", {m_vld, busy}); end
        tick();
        m_resp_vld = 1'b1; m_rd = 32'hCAFE; tick(); m_resp_vld = 1'b0;
        n_cmp++; if ({resp_vld, resp_err, resp_rd} !== {4'b0001, 1'b0, 32'hCAFE}) begin
            n_bad++; $display("FAIL sr_resp: got vld=%b err=%b rd=%h, expected 0001/0/cafe", resp_vld, resp_err, resp_rd); end
        tick();
        n_cmp++; if ({resp_vld, busy, resp_rd} !== {4'b0000, 1'b0, 32'hCAFE}) begin
            n_bad++; $display("FAIL sr_hold: got vld=%b busy=%b rd=%h", resp_vld, busy, resp_rd); end
    endtask

    task automatic test_contention();
        int g[$], r[$], gc[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; tick(); rst = 1'b0;
        m_rdy = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (g.size() == 5 && !busy && resp_vld == '0) break;
            req_vld = (g.size() < 5) ? 4'b1111 : 4'b0000;
            m_resp_vld = busy && !m_vld; m_rd = $urandom;
            #1;
            if (req_rdy != '0) begin g.push_back(oh2id(req_rdy)); gc.push_back(c); end
            tick();
            if (resp_vld != '0) r.push_back(oh2id(resp_vld));
        end
        m_resp_vld = 1'b0; req_vld = '0;
        n_cmp++; if (g.size() != 5 || r.size() != 5) begin
            n_bad++; $display("FAIL cont_count: got %0d grants %0d resps, expected 5/5", g.size(), r.size()); end
        for (int i = 0; i < g.size() && i < 5; i++) begin
            n_cmp++; if (g[i] != exp_order[i]) begin n_bad++; $display("FAIL cont_order[%0d]: got %0d, expected %0d", i, g[i], exp_order[i]); end
            if (i < r.size()) begin
                n_cmp++; if (r[i] != g[i]) begin n_bad++; $display("FAIL cont_resp[%0d]: got %0d, expected %0d", i, r[i], g[i]); end
            end
            if (i > 0) begin
                n_cmp++; if (gc[i] - gc[i-1] != 4) begin n_bad++; $display("FAIL cont_gap[%0d]: got %0d, expected 4", i, gc[i] - gc[i-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a = $urandom, w = $urandom;
        req_addr[2*32 +: 32] = a; req_wd[2*32 +: 32] = w; req_we[2] = 1'b1;
        req_vld = 4'b0100; m_rdy = 1'b0; #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL bp_grant: got %b, expected 0100", req_rdy); end
        tick(); req_vld = '0;
        for (int c = 1; c <= 5; c++) begin
            n_cmp++; if ({m_vld, m_we, m_addr, m_wd} !== {1'b1, 1'b1, a, w}) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got vld=%b addr=%h wd=%h, expected 1/%h/%h", c, m_vld, m_addr, m_wd, a, w); end
            tick();
        end
        m_rdy = 1'b1;
        n_cmp++; if ({m_vld, m_addr, m_wd} !== {1'b1, a, w}) begin
            n_bad++; $display("FAIL bp_cyc6: got vld=%b addr=%h, expected 1/%h", m_vld, m_addr, a); end
        tick();
        n_cmp++; if ({m_vld, busy} !== 2'b01) begin n_bad++; $display("FAIL bp_hs: got %b, expected 01", {m_vld, busy}); end
        m_resp_vld = 1'b1; m_rd = $urandom; tick(); m_resp_vld = 1'b0;
        n_cmp++; if ({resp_vld, resp_err} !== {4'b0100, 1'b0}) begin
            n_bad++; $display("FAIL bp_resp: got %b/%b, expected 0100/0", resp_vld, resp_err); end
        tick();
    endtask

    task automatic test_timeout();
        int k = 0;
        bit found = 0;
        req_addr[1*32 +: 32] = $urandom; req_we[1] = 1'b0; req_vld = 4'b0010; m_rdy = 1'b1;
        tick(); req_vld = '0;
        tick();
        while (k < 20 && !found) begin
            tick(); k++;
            if (resp_vld != '0) found = 1;
        end
        n_cmp++; if (!found || k != TO) begin n_bad++; $display("FAIL to_cycle: got found=%0d at %0d, expected %0d", found, k, TO); end
        n_cmp++; if ({resp_vld, resp_err, resp_rd} !== {4'b0010, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL to_resp: got vld=%b err=%b rd=%h, expected 0010/1/0", resp_vld, resp_err, resp_rd); end
        m_resp_vld = 1'b1; m_rd = 32'hDEAD; tick(); m_resp_vld = 1'b0;
        n_cmp++; if ({resp_vld, busy, resp_err, resp_rd} !== {4'b0, 1'b0, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL to_late: got vld=%b busy=%b err=%b rd=%h", resp_vld, busy, resp_err, resp_rd); end
    endtask

    task automatic test_reset_in_wait();
        req_vld = 4'b1000; m_rdy = 1'b1;
        tick(); req_vld = '0;
        tick();
        n_cmp++; if ({busy, m_vld} !== 2'b10) begin n_bad++; $display("FAIL rw_wait: got %b, expected 10", {busy, m_vld}); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if ({busy, m_vld, resp_vld} !== 6'd0) begin
            n_bad++; $display("FAIL rw_abort: got %b, expected 0", {busy, m_vld, resp_vld}); end
        m_resp_vld = 1'b1; tick(); m_resp_vld = 1'b0;
        n_cmp++; if ({busy, resp_vld} !== 5'd0) begin n_bad++; $display("FAIL rw_noresp: got %b, expected 0", {busy, resp_vld}); end
        req_vld = 4'b1111; #1;
        n_cmp++; if (req_rdy !== 4'b0001) begin n_bad++; $display("FAIL rw_first: got %b, expected 0001", req_rdy); end
        req_vld = '0;
    endtask

    task automatic test_withdraw();
        bit bad = 0;
        req_vld = 4'b0010; m_rdy = 1'b1;
        tick(); req_vld = '0;
        tick();
        req_vld = 4'b0100; #1;
        n_cmp++; if (req_rdy !== '0) begin n_bad++; $display("FAIL wd_rdy: got %b, expected 0", req_rdy); end
        tick(); req_vld = '0;
        n_cmp++; if ({m_vld, busy} !== 2'b01) begin n_bad++; $display("FAIL wd_nomvld: got %b, expected 01", {m_vld, busy}); end
        m_resp_vld = 1'b1; m_rd = $urandom; tick(); m_resp_vld = 1'b0;
        n_cmp++; if (resp_vld !== 4'b0010) begin n_bad++; $display("FAIL wd_resp: got %b, expected 0010", resp_vld); end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (busy || m_vld) bad = 1;
        end
        n_cmp++; if (bad) begin n_bad++; $display("FAIL wd_idle: got activity after withdrawn request, expected none"); end
        req_vld = 4'b1111; #1;
        n_cmp++; if (req_rdy !== 4'b0100) begin n_bad++; $display("FAIL wd_ptr: got %b, expected 0100", req_rdy); end
        req_vld = '0;
    endtask

    // Transaction-level model: tracks the owner, whether its bus request has
    // been accepted and how long it has waited, and predicts each completion.
    task automatic test_random(int ncyc);
        int          ptr_m = N - 1, last_id = 0, t_id = 0, k = 0;
        bit          pend = 0, issued = 0, exp_resp = 0;
        logic [31:0] t_addr = 0, t_wd = 0, exp_rd = 0;
        logic        t_we = 0, exp_err = 0;
        logic [N-1:0] rdy_s = '0, exp_rdy;
        rst = 1'b1; req_vld = '0; m_rdy = 1'b0; m_resp_vld = 1'b0;
        tick(); rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            exp_resp = 0;
            if (rdy_s != '0) begin
                t_id = oh2id(rdy_s);
                t_addr = req_addr[t_id*32 +: 32]; t_wd = req_wd[t_id*32 +: 32]; t_we = req_we[t_id];
                pend = 1; issued = 0; ptr_m = t_id; last_id = t_id;
                req_vld[t_id] = 1'b0;
            end else if (pend && issued) begin
                k++;
                if (m_resp_vld) begin
                    exp_resp = 1; exp_rd = m_rd; exp_err = 0; pend = 0; issued = 0;
                end else if (k == TO) begin
                    exp_resp = 1; exp_rd = 0; exp_err = 1; pend = 0; issued = 0;
                end
            end else if (pend && m_rdy) begin
                issued = 1; k = 0;
            end
            n_cmp++; if (resp_vld !== (exp_resp ? N'(1 << t_id) : N'(0))) begin
                n_bad++; $display("FAIL rnd_resp_vld c=%0d: got %b, expected %b", c, resp_vld, exp_resp ? N'(1 << t_id) : N'(0)); end
            n_cmp++; if ({resp_err, resp_rd} !== {exp_err, exp_rd}) begin
                n_bad++; $display("FAIL rnd_resp_data c=%0d: got %b/%h, expected %b/%h", c, resp_err, resp_rd, exp_err, exp_rd); end
            n_cmp++; if ({busy, m_vld, cur_id} !== {pend, pend && !issued, 2'(last_id)}) begin
                n_bad++; $display("FAIL rnd_ctl c=%0d: got %b, expected %b", c, {busy, m_vld, cur_id}, {pend, pend && !issued, 2'(last_id)}); end
            if (pend && !issued) begin
                n_cmp++; if ({m_we, m_addr, m_wd} !== {t_we, t_addr, t_wd}) begin
                    n_bad++; $display("FAIL rnd_mfields c=%0d: got %b/%h/%h, expected %b/%h/%h", c, m_we, m_addr, m_wd, t_we, t_addr, t_wd); end
            end
            for (int i = 0; i < N; i++) begin
                if (req_vld[i]) begin
                    if ($urandom_range(0, 19) == 0) req_vld[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_vld[i] = 1'b1;
                    req_addr[i*32 +: 32] = $urandom; req_wd[i*32 +: 32] = $urandom;
                    req_we[i] = 1'($urandom_range(0, 1));
                end
            end
            m_rdy = ($urandom_range(0, 2) != 0);
            m_resp_vld = (pend && issued) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            m_rd = $urandom;
            #1;
            exp_rdy = (!pend && !exp_resp) ? rr_win(ptr_m, req_vld) : '0;
            n_cmp++; if (req_rdy !== exp_rdy) begin
                n_bad++; $display("FAIL rnd_rdy c=%0d: got %b, expected %b (vld=%b)", c, req_rdy, exp_rdy, req_vld); end
            rdy_s = exp_rdy;
        end
        req_vld = '0; m_resp_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_vld = '0; req_we = '0; req_addr = '0; req_wd = '0;
        m_rdy = 1'b0; m_resp_vld = 1'b0; m_rd = '0;
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_in_wait();
        test_withdraw();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
